// File: rtl/cr_tlv_ftr_patch_pipe.sv
// cr_tlv_ftr_patch_pipe: registered TLV pass-through that patches the footer bytes_out field; stat counters built only when CR_TLV_FTR_PATCH_STATS_EN is defined
module cr_tlv_ftr_patch_pipe #(
  parameter int         DATA_W    = 64,
  parameter logic [7:0] FTR_TYPE  = 8'h0A,
  parameter logic [7:0] DATA_TYPE = 8'h05,
  parameter int         FTR_WORD  = 12,
  parameter int         BIN_LSB   = 0,
  parameter int         BOUT_LSB  = 32,
  parameter int         CNT_W     = 24
) (
  input  logic                clk,
  input  logic                rst_sync_n,
  input  logic                ib_tvalid,
  input  logic                ib_tlast,
  input  logic [DATA_W-1:0]   ib_tdata,
  input  logic [DATA_W/8-1:0] ib_tstrb,
  input  logic [7:0]          ib_tuser,
  input  logic                ib_tid,
  output logic                ib_tready,
  output logic                ob_tvalid,
  output logic                ob_tlast,
  output logic [DATA_W-1:0]   ob_tdata,
  output logic [DATA_W/8-1:0] ob_tstrb,
  output logic [7:0]          ob_tuser,
  output logic                ob_tid,
  input  logic                ob_tready,
  input  logic                cfg_count_mode,
  output logic                ftr_patched,
  output logic                ftr_short_err,
  output logic [15:0]         stat_patched_cnt,
  output logic [15:0]         stat_err_cnt
);
  localparam int SW = DATA_W/8;
  localparam int EW = 1+DATA_W+SW+8+1;
  localparam int IW = $clog2(FTR_WORD+2);
  typedef enum logic [1:0] {IDLE, DATA, FTR, OTHER} st_t;
  st_t st, ctx, nst;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] sum;
  logic [IW-1:0] fidx, cidx;
  logic [EW-1:0] mem [2];
  logic [1:0] occ;
  logic wp, rp, acc, pop, patch, short_e, is_first;
  logic [DATA_W-1:0] pdata;
  function automatic logic [CNT_W-1:0] popc(input logic [SW-1:0] s);
    popc = '0;
    for (int i = 0; i < SW; i++) popc = popc + CNT_W'(s[i]);
  endfunction
  assign ib_tready = occ != 2'd2;
  assign acc = ib_tvalid & ib_tready;
  assign ob_tvalid = occ != 2'd0;
  assign pop = ob_tvalid & ob_tready;
  assign {ob_tlast, ob_tdata, ob_tstrb, ob_tuser, ob_tid} = mem[rp];
  // Classify the current beat, find its footer index and build the patched data word
  always_comb begin
    is_first = ib_tuser[0];
    ctx = is_first ? (ib_tdata[7:0] == DATA_TYPE ? DATA : ib_tdata[7:0] == FTR_TYPE ? FTR : OTHER) : (st == IDLE ? OTHER : st);
    nst = ib_tuser[1] ? IDLE : ctx;
    cidx = is_first ? '0 : fidx;
    patch = ctx == FTR && cidx == IW'(FTR_WORD);
    short_e = ctx == FTR && ib_tuser[1] && cidx < IW'(FTR_WORD);
    sum = {1'b0, cnt} + {1'b0, popc(ib_tstrb)};
    pdata = ib_tdata;
    if (patch) pdata[BOUT_LSB+:CNT_W] = cfg_count_mode ? cnt : ib_tdata[BIN_LSB+:CNT_W];
  end
  // Parser state, payload byte counter, footer index and status pulses
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      st <= IDLE;
      cnt <= '0;
      fidx <= '0;
      ftr_patched <= 1'b0;
      ftr_short_err <= 1'b0;
    end else begin
      ftr_patched <= acc && patch;
      ftr_short_err <= acc && short_e;
      if (acc) begin
        st <= nst;
        if (ctx == FTR) fidx <= cidx == IW'(FTR_WORD+1) ? cidx : cidx + 1'b1;
        if (ctx == FTR && ib_tuser[1]) cnt <= '0;
        else if (ctx == DATA && !is_first) cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end
  end
  // Two-entry FIFO; ready depends only on registered occupancy
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      occ <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (acc) begin
        mem[wp] <= {ib_tlast, pdata, ib_tstrb, ib_tuser, ib_tid};
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      occ <= occ + {1'b0, acc} - {1'b0, pop};
    end
  end
`ifdef CR_TLV_FTR_PATCH_STATS_EN
  // Saturating event counters for patched footers and short footers
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      stat_patched_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (ftr_patched && stat_patched_cnt != 16'hFFFF) stat_patched_cnt <= stat_patched_cnt + 1'b1;
      if (ftr_short_err && stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 1'b1;
    end
  end
`else
  assign stat_patched_cnt = '0;
  assign stat_err_cnt = '0;
`endif
endmodule

// File: doc/cr_tlv_ftr_patch_pipe.md
# cr_tlv_ftr_patch_pipe

Parametrised successor to the xp10 decompressor stub datapath: a registered AXI4-stream TLV pass-through that patches the footer `bytes_out` field. It either copies `bytes_in` or substitutes the measured DATA-TLV payload byte count. It sits between the decompressor ingress and egress whenever the decompression core is compiled out or bypassed. It adds full-throughput 2-entry buffering, footer-length checking and per-frame status pulses.

## Interface
- `DATA_W`, 64 — tdata width; multiple of 8.
- `FTR_TYPE`, 8'h??=FTR enum value — TLV type code identifying the footer.
- `DATA_TYPE`, DATA enum value — TLV type code whose payload is byte-counted.
- `FTR_WORD`, 12 — index of the patched footer beat; the first footer beat is 0.
- `BIN_LSB`, 0 — LSB of the `bytes_in` field within the patched beat.
- `BOUT_LSB`, 32 — LSB of the `bytes_out` field within the patched beat.
- `CNT_W`, 24 — width of `bytes_in`, `bytes_out` and the byte counter.
- `clk` in 1 — clock.
- `rst_sync_n` in 1 — reset; asynchronous, active-low.
- `ib_tvalid`, `ib_tlast` in 1 — input beat valid and last.
- `ib_tdata` in DATA_W — input data; `[7:0]` carries the TLV type on the first beat.
- `ib_tstrb` in DATA_W/8 — input byte strobes.
- `ib_tuser` in 8 — `[0]` marks the TLV first beat, `[1]` marks the TLV last beat.
- `ib_tid` in 1 — input stream id.
- `ib_tready` out 1 — input ready.
- `ob_tvalid`, `ob_tlast`, `ob_tdata`, `ob_tstrb`, `ob_tuser`, `ob_tid` out — output beat; same widths as the input.
- `ob_tready` in 1 — output ready.
- `cfg_count_mode` in 1 — 0: `bytes_out = bytes_in`; 1: `bytes_out` = counted payload bytes.
- `ftr_patched` out 1 — one-cycle pulse when the patched beat is accepted.
- `ftr_short_err` out 1 — one-cycle pulse when a footer ends before beat FTR_WORD.
- `stat_patched_cnt`, `stat_err_cnt` out 16 — saturating event counters (see Configuration).

## Operation
- Accept: `ib_tvalid & ib_tready`. Every accepted beat enters the 2-entry FIFO unmodified, except the patched beat.
- Parser FSM; transitions occur only on accepted beats.
  - IDLE → DATA when `tuser[0]` and type == DATA_TYPE.
  - IDLE → FTR when `tuser[0]` and type == FTR_TYPE.
  - IDLE → OTHER on `tuser[0]` with any other type.
  - Any state → IDLE on a beat with `tuser[1]`.
  - A single-beat TLV (`tuser[0]` and `tuser[1]` on the same beat) returns to IDLE in the same cycle.
  - A `tuser[0]` beat arriving while not in IDLE restarts parsing from that beat's type. No error is raised.
- Byte counter, CNT_W bits, saturating at all-ones:
  - On DATA-TLV beats other than the first, add popcount(`tstrb`).
  - Clear to 0 when the footer's last beat is accepted.
- Footer beat index: 0 on the `tuser[0]` beat, incrementing per accepted footer beat, saturating at FTR_WORD+1.
- Patch, applied when in footer context and index == FTR_WORD:
  - mode 0: `tdata[BOUT_LSB+:CNT_W] = tdata[BIN_LSB+:CNT_W]`.
  - mode 1: `tdata[BOUT_LSB+:CNT_W]` = counter value including the current beat's contribution. The current beat's contribution is 0 because it is a footer beat.
  - All other bits pass unchanged.
  - Assert `ftr_patched` the next cycle.
- Footer last beat accepted with index < FTR_WORD:
  - Assert `ftr_short_err` the next cycle.
  - No patch is performed and the counter still clears.
- `cfg_count_mode` is sampled on the patched beat only.
- Reset mid-frame: all state is discarded and the FSM returns to IDLE. The first beat after reset must carry `tuser[0]`; otherwise its TLV is treated as OTHER until `tuser[1]`.

## Timing
- Reset values:
  - `ob_tvalid`=0 and all `ob_*` data=0.
  - `ftr_patched`=`ftr_short_err`=0; stat counters=0.
  - FIFO empty, FSM IDLE, counter 0.
  - `ib_tready`=1 from the first clock after reset release.
- Latency: an input beat accepted in cycle N is presented on `ob_*` in cycle N+1 when the FIFO was empty.
- `ib_tready` = !(FIFO holds 2 entries), decoded from registered occupancy only. There is no combinational path from `ob_tready`.
- Throughput: 1 beat/cycle sustained while `ob_tready`=1.
- Simultaneous push and pop when full: not allowed, since ready is low. Simultaneous push and pop at occupancy 1 keeps occupancy 1.
- `ob_*` holds stable while `ob_tvalid & !ob_tready`.
- Status pulses are registered, exactly one cycle wide, and aligned one cycle after input acceptance.

## Configuration
- `CR_TLV_FTR_PATCH_STATS_EN` defined: `stat_patched_cnt` and `stat_err_cnt` increment on `ftr_patched` and `ftr_short_err` respectively, saturating at 16'hFFFF, reset to 0.
- `CR_TLV_FTR_PATCH_STATS_EN` undefined: both outputs are tied to 0 and no counter flops exist. Pulses and datapath are unaffected.

## Test plan
- Frame, mode 0: DATA TLV of 1 header beat + 4 full beats, then a 14-beat FTR whose beat 12 has `bytes_in`=0x000123 → `ob` beat 12 has `bytes_out`=0x000123, all other bits identical; `ftr_patched` one pulse.
- Same frame, mode 1: payload beats with `tstrb` 0xFF, 0xFF, 0xFF, 0x0F → `bytes_out`=28; counter is 0 at the next frame.
- Short footer: FTR of 10 beats → no beat modified; `ftr_short_err` pulses once; stat_err_cnt=1 with the macro defined, 0 without.
- Backpressure: `ob_tready` low for 5 cycles during the frame → `ib_tready` drops after 2 accepted beats; no beat lost or duplicated; order preserved; full rate resumes.
- Reset asserted mid-DATA TLV, then a new frame → outputs return to reset values, counter restarts at 0, and mode 1 `bytes_out` reflects only the new frame.
- Back-to-back single-beat OTHER TLVs (`tuser`=2'b11) at full rate → 1 beat/cycle, 1-cycle latency, no patch, no error.
